// File: rtl/float16_div.sv
// Sign-magnitude divider: 31-bit product word over a 16-bit divisor.
// Fast paths finish in one cycle; the rest use a 15-step restoring loop.
module float16_div (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iStart,
  input  logic [30:0] iNum,
  input  logic [15:0] iDiv,
  output logic [15:0] oNum,
  output logic        oBusy,
  output logic        oDone,
  output logic        oDivZero,
  output logic        oOvf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [14:0] rem;
  logic [14:0] lo;
  logic [13:0] quo;
  logic [14:0] dvs;
  logic        sgn;
  logic [3:0]  cnt;

  logic        is_unity;
  logic        is_zero;
  logic        num_zero;
  logic        is_ovf;
  logic        fast;
  logic        res_sgn;

  logic [15:0] shifted;
  logic        qbit;
  logic [14:0] rem_nxt;
  logic        last;

  // 16'h8000 is the unity code, so it is not treated as a zero divisor.
  assign is_unity = (iDiv == 16'h8000);
  assign is_zero  = (iDiv[14:0] == 15'd0) && !is_unity;
  assign num_zero = (iNum[29:0] == 30'd0);
  assign is_ovf   = (iNum[29:15] >= iDiv[14:0]);
  assign fast     = is_unity | is_zero | num_zero | is_ovf;
  assign res_sgn  = iNum[30] ^ iDiv[15];

  // Remainder stays below the divisor, so the shifted value fits 16 bits.
  assign shifted = {rem, lo[14]};
  assign qbit    = (shifted >= {1'b0, dvs});
  assign rem_nxt = qbit ? 15'(shifted - {1'b0, dvs})
                        : shifted[14:0];
  assign last    = (cnt == 4'd14);

  assign oBusy = (state == CALC);
  assign oDone = (state == DONE);

  // State register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (iStart) begin
          state_nxt = fast ? DONE : CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, fast-path results and restoring iterations.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rem      <= '0;
      lo       <= '0;
      quo      <= '0;
      dvs      <= '0;
      sgn      <= 1'b0;
      cnt      <= '0;
      oNum     <= '0;
      oDivZero <= 1'b0;
      oOvf     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (iStart) begin
            rem      <= iNum[29:15];
            lo       <= iNum[14:0];
            quo      <= '0;
            dvs      <= iDiv[14:0];
            sgn      <= res_sgn;
            cnt      <= '0;
            oDivZero <= 1'b0;
            oOvf     <= 1'b0;
            if (is_unity) begin
              oNum <= iNum[30:15];
            end else if (is_zero) begin
              oNum     <= {res_sgn, 15'h7FFF};
              oDivZero <= 1'b1;
            end else if (num_zero) begin
              oNum <= 16'h0000;
            end else if (is_ovf) begin
              oNum <= {res_sgn, 15'h7FFF};
              oOvf <= 1'b1;
            end
          end
        end
        CALC: begin
          rem <= rem_nxt;
          lo  <= {lo[13:0], 1'b0};
          quo <= {quo[12:0], qbit};
          cnt <= cnt + 4'd1;
          if (last) begin
            oNum <= {sgn, quo, qbit};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float16_div.sv
// Bench for float16_div: arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed literal results.
module tb_float16_div;

  logic        iClk;
  logic        iRst_n;
  logic        iStart;
  logic [30:0] iNum;
  logic [15:0] iDiv;
  logic [15:0] oNum;
  logic        oBusy;
  logic        oDone;
  logic        oDivZero;
  logic        oOvf;

  int errors = 0;
  int checks = 0;
  bit en = 0;

  float16_div dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iStart   (iStart),
    .iNum     (iNum),
    .iDiv     (iDiv),
    .oNum     (oNum),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oDivZero (oDivZero),
    .oOvf     (oOvf)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: cycle-numbered timeline of the operation.
  int          cyc = 0;
  int          e0 = -100;
  int          dcyc = -100;
  bit          mfast = 1;
  logic [15:0] res_num = '0;
  bit          res_dz = 0;
  bit          res_ovf = 0;
  logic [15:0] sh_num = '0;
  bit          sh_dz = 0;
  bit          sh_ovf = 0;
  int unsigned mn;
  int unsigned md;
  bit          ms;

  always @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      e0 = -100;
      dcyc = -100;
      mfast = 1;
      sh_num = '0;
      sh_dz = 0;
      sh_ovf = 0;
    end else begin
      if (iStart && cyc > dcyc) begin
        mn = iNum[29:0];
        md = iDiv[14:0];
        ms = iNum[30] ^ iDiv[15];
        mfast = 1;
        res_dz = 0;
        res_ovf = 0;
        if (iDiv == 16'h8000) begin
          res_num = iNum[30:15];
        end else if (md == 0) begin
          res_num = {ms, 15'h7FFF};
          res_dz = 1;
        end else if (mn == 0) begin
          res_num = 16'h0000;
        end else if (mn / md >= 32768) begin
          res_num = {ms, 15'h7FFF};
          res_ovf = 1;
        end else begin
          mfast = 0;
          res_num = {ms, 15'(mn / md)};
        end
        e0 = cyc + 1;
        dcyc = e0 + (mfast ? 0 : 15);
        sh_dz = 0;
        sh_ovf = 0;
      end
      cyc++;
      if (cyc == dcyc) begin
        sh_num = res_num;
        sh_dz = res_dz;
        sh_ovf = res_ovf;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge iClk) begin
    if (en) begin
      chk("busy", {15'd0, oBusy},
          {15'd0, !mfast && cyc >= e0 && cyc <= e0 + 14});
      chk("done", {15'd0, oDone}, {15'd0, cyc == dcyc});
      chk("onum", oNum, sh_num);
      chk("divzero", {15'd0, oDivZero}, {15'd0, sh_dz});
      chk("ovf", {15'd0, oOvf}, {15'd0, sh_ovf});
    end
  end

  task automatic start_op(input logic [30:0] n,
                          input logic [15:0] d);
    @(negedge iClk);
    iNum = n;
    iDiv = d;
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    iNum = 31'($urandom);
    iDiv = 16'($urandom);
  endtask

  task automatic wait_done(input logic [15:0] ln,
                           input logic ldz,
                           input logic lovf,
                           input int lat,
                           input string nm);
    int n = 0;
    int b = 0;
    forever begin
      @(negedge iClk);
      if (oBusy) b++;
      if (oDone) break;
      n++;
      if (n > 40) begin
        errors++;
        checks++;
        $display("FAIL %s timeout: no done after %0d", nm, n);
        return;
      end
    end
    chk({nm, "_num"}, oNum, ln);
    chk({nm, "_dz"}, {15'd0, oDivZero}, {15'd0, ldz});
    chk({nm, "_ovf"}, {15'd0, oOvf}, {15'd0, lovf});
    if (lat >= 0) begin
      chk({nm, "_lat"}, 16'(n), 16'(lat));
      chk({nm, "_busy"}, 16'(b), 16'(lat));
    end
  endtask

  typedef struct {
    logic [30:0] n;
    logic [15:0] d;
    logic [15:0] q;
    logic        dz;
    logic        ovf;
    int          lat;
    string       nm;
  } vec_t;

  vec_t v[12];

  initial begin
    v[0]  = '{{1'b0, 30'd1000000}, {1'b1, 15'd1000},
              16'h83E8, 0, 0, 15, "normal"};
    v[1]  = '{31'd100, 16'd7, 16'h000E, 0, 0, 15, "trunc"};
    v[2]  = '{{1'b1, 30'd5}, 16'h0000, 16'hFFFF, 1, 0, 0, "divzero"};
    v[3]  = '{31'h00FFFFFF, 16'h0001, 16'h7FFF, 0, 1, 0, "ovf"};
    v[4]  = '{31'h12345678, 16'h8000, 16'h2468, 0, 0, 0, "unity"};
    v[5]  = '{{1'b1, 30'd0}, 16'd3, 16'h0000, 0, 0, 0, "numzero"};
    v[6]  = '{{1'b0, 30'd163840}, 16'd5, 16'h7FFF, 0, 1, 0, "ovf_edge"};
    v[7]  = '{{1'b0, 30'd163839}, {1'b1, 15'd5},
              16'hFFFF, 0, 0, 15, "below_edge"};
    v[8]  = '{{1'b1, 30'd6}, 16'd7, 16'h8000, 0, 0, 15, "qzero"};
    v[9]  = '{31'h7FFF8000, 16'h8000, 16'hFFFF, 0, 0, 0, "unity_neg"};
    v[10] = '{{1'b0, 30'h3FFFFFFF}, {1'b1, 15'h7FFF},
              16'hFFFF, 0, 1, 0, "ovf_max"};
    v[11] = '{{1'b0, 30'd12345678}, 16'd4000,
              16'h0C0E, 0, 0, 15, "normal2"};
  end

  initial begin
    int extra;
    iRst_n = 1'b0;
    iStart = 1'b0;
    iNum = '0;
    iDiv = '0;
    repeat (3) @(negedge iClk);
    chk("rst_num", oNum, 16'h0000);
    chk("rst_busy", {15'd0, oBusy}, 16'd0);
    chk("rst_done", {15'd0, oDone}, 16'd0);
    chk("rst_flags", {14'd0, oDivZero, oOvf}, 16'd0);
    iRst_n = 1'b1;
    en = 1;

    // Back-to-back directed vectors.
    for (int i = 0; i < 12; i++) begin
      start_op(v[i].n, v[i].d);
      wait_done(v[i].q, v[i].dz, v[i].ovf, v[i].lat, v[i].nm);
    end

    // Start pulse during CALC must be ignored.
    start_op({1'b0, 30'd1000000}, {1'b0, 15'd1000});
    repeat (5) @(negedge iClk);
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    wait_done(16'h03E8, 0, 0, -1, "ignore");
    extra = 0;
    repeat (20) begin
      @(negedge iClk);
      if (oDone) extra++;
    end
    chk("ignore_extra_done", 16'(extra), 16'd0);

    // Asynchronous reset in the middle of CALC.
    start_op(31'd100, 16'd7);
    repeat (8) @(posedge iClk);
    #2;
    iRst_n = 1'b0;
    #1;
    chk("abort_num", oNum, 16'h0000);
    chk("abort_busy", {15'd0, oBusy}, 16'd0);
    chk("abort_done", {15'd0, oDone}, 16'd0);
    chk("abort_flags", {14'd0, oDivZero, oOvf}, 16'd0);
    iStart = 1'b1;
    repeat (3) @(negedge iClk);
    chk("rst_hold_busy", {15'd0, oBusy}, 16'd0);
    iStart = 1'b0;
    iRst_n = 1'b1;
    start_op({1'b0, 30'd1000000}, {1'b1, 15'd1000});
    wait_done(16'h83E8, 0, 0, 15, "post_rst");

    repeat (3) @(negedge iClk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
